chol_inv_sched: RTL and testbench

- Sequencer for the Cholesky-then-inverse pipeline.
- Walks column by column through the phases sqrt, Cholesky divide, Cholesky multiply-accumulate and inverse multiply-accumulate.
- Arbitrates the single shared array divider and array multiplier between the Cholesky and inverse engines, and drives their step indices.
- Replaces hard-coded count tables in the top level with a parameterised FSM and a phase timer.

---
 rtl/chol_inv_sched_pkg.sv | 27 ++
 rtl/chol_inv_sched_timer.sv | 35 +++
 rtl/chol_inv_sched.sv | 152 +++++++++++++++
 tb/tb_chol_inv_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chol_inv_sched_pkg.sv
// Shared types and constants for the Cholesky/inverse sequencer.
package chol_inv_sched_pkg;

  localparam int STEP_W = 5;
  localparam int COL_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQRT = 3'd1,
    ST_CDIV = 3'd2,
    ST_CMAC = 3'd3,
    ST_IMAC = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CHOL = 2'd1,
    OWN_INV  = 2'd2
  } owner_t;

  // True for the four timed compute phases.
  function automatic logic is_phase(state_t s);
    return (s == ST_SQRT) || (s == ST_CDIV) || (s == ST_CMAC) || (s == ST_IMAC);
  endfunction

endpackage

// File: rtl/chol_inv_sched_timer.sv
// Phase timer: counts 0..len-1 after each load, flags first and last cycle.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             en,
  output logic             tc,
  output logic             first
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  // Restart on load, otherwise advance and saturate at the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      last  <= '0;
      first <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      last  <= len - CNT_W'(1);
      first <= 1'b1;
    end else if (en) begin
      first <= 1'b0;
      if (cnt != last) cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = en && (cnt == last);

endmodule

// File: rtl/chol_inv_sched.sv
// Column-by-column sequencer for the Cholesky-then-inverse pipeline.
// Owns the shared divider/multiplier arbitration and the engine step indices.
module chol_inv_sched
  import chol_inv_sched_pkg::*;
#(
  parameter int N        = 6,
  parameter int SQRT_LAT = 5,
  parameter int DIV_LAT  = 5,
  parameter int MAC_LAT  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [COL_W-1:0]  col,
  output logic [STEP_W-1:0] chol_step,
  output logic [STEP_W-1:0] inv_step,
  output logic [1:0]        div_sel,
  output logic              div_issue,
  output logic [1:0]        mult_sel,
  output logic              mult_issue
);

  localparam int MAX_LAT0 = (SQRT_LAT > DIV_LAT) ? SQRT_LAT : DIV_LAT;
  localparam int MAX_LAT  = (MAX_LAT0 > MAC_LAT) ? MAX_LAT0 : MAC_LAT;
  localparam int CNT_W    = $clog2(MAX_LAT) + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

  state_t             state, state_nxt;
  logic [COL_W-1:0]   col_nxt;
  logic [STEP_W-1:0]  chol_nxt, inv_nxt, col_x3, col_x2;
  owner_t             div_own, mult_own, div_nxt, mult_nxt;
  logic               load, en, tc, first;
  logic [CNT_W-1:0]   phase_len;

  function automatic logic [CNT_W-1:0] lat_of(state_t s);
    case (s)
      ST_SQRT:          return CNT_W'(SQRT_LAT);
      ST_CDIV:          return CNT_W'(DIV_LAT);
      ST_CMAC, ST_IMAC: return CNT_W'(MAC_LAT);
      default:          return CNT_W'(1);
    endcase
  endfunction

  // Next state and column; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    case (state)
      ST_IDLE: if (start) begin
        state_nxt = ST_SQRT;
        col_nxt   = '0;
      end
      ST_SQRT: if (tc) state_nxt = ST_CDIV;
      ST_CDIV: if (tc) state_nxt = ST_CMAC;
      ST_CMAC: if (tc) state_nxt = ST_IMAC;
      ST_IMAC: if (tc) begin
        if (col < LAST_COL) begin
          state_nxt = ST_SQRT;
          col_nxt   = col + COL_W'(1);
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
    if (state_nxt == ST_IDLE) col_nxt = '0;
  end

  // The timer is reloaded on every entry into a compute phase.
  assign load      = (state_nxt != state) && is_phase(state_nxt);
  assign phase_len = lat_of(state_nxt);
  assign en        = is_phase(state);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .len   (phase_len),
    .en    (en),
    .tc    (tc),
    .first (first)
  );

  // Step indices and resource owners for the state being entered.
  always_comb begin
    col_x3   = STEP_W'(col_nxt) * STEP_W'(3);
    col_x2   = STEP_W'(col_nxt) * STEP_W'(2);
    chol_nxt = chol_step;
    inv_nxt  = inv_step;
    div_nxt  = OWN_NONE;
    mult_nxt = OWN_NONE;
    case (state_nxt)
      ST_IDLE: begin
        chol_nxt = '0;
        inv_nxt  = '0;
      end
      ST_SQRT: chol_nxt = col_x3 + STEP_W'(1);
      ST_CDIV: begin
        chol_nxt = col_x3 + STEP_W'(2);
        div_nxt  = OWN_CHOL;
      end
      ST_CMAC: begin
        chol_nxt = col_x3 + STEP_W'(3);
        inv_nxt  = col_x2 + STEP_W'(1);
        div_nxt  = OWN_INV;
        mult_nxt = OWN_CHOL;
      end
      ST_IMAC: begin
        inv_nxt  = col_x2 + STEP_W'(2);
        mult_nxt = OWN_INV;
      end
      default: ;
    endcase
  end

  // Registered state and outputs, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col       <= '0;
      chol_step <= '0;
      inv_step  <= '0;
      div_own   <= OWN_NONE;
      mult_own  <= OWN_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      chol_step <= chol_nxt;
      inv_step  <= inv_nxt;
      div_own   <= div_nxt;
      mult_own  <= mult_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
    end
  end

  assign div_sel  = div_own;
  assign mult_sel = mult_own;

  // Load strobes fire on the timer's registered first-cycle flag, so a
  // one-cycle phase still yields a single-cycle strobe.
  assign div_issue  = first && ((state == ST_CDIV) || (state == ST_CMAC));
  assign mult_issue = first && ((state == ST_CMAC) || (state == ST_IMAC));

endmodule

// File: tb/tb_chol_inv_sched.sv
// Self-checking bench for chol_inv_sched: default instance and a small
// N=2 / unit-latency instance, both checked every cycle against a
// closed-form model of the run timeline.
module tb_chol_inv_sched;

  localparam int NA = 6, SA = 5, DA = 5, MA = 6;
  localparam int NB = 2, SB = 1, DB = 1, MB = 1;
  localparam int PA = SA + DA + 2 * MA;
  localparam int PB = SB + DB + 2 * MB;

  typedef struct packed {
    logic [2:0] col;
    logic [4:0] chol;
    logic [4:0] inv;
    logic [1:0] ds;
    logic [1:0] ms;
    logic       di;
    logic       mi;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, abort_a, start_b, abort_b;
  logic [2:0] col_a, col_b;
  logic [4:0] chol_a, chol_b, inv_a, inv_b;
  logic [1:0] ds_a, ds_b, ms_a, ms_b;
  logic di_a, di_b, mi_a, mi_b, busy_a, busy_b, done_a, done_b;

  chol_inv_sched #(.N(NA), .SQRT_LAT(SA), .DIV_LAT(DA), .MAC_LAT(MA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .col(col_a), .chol_step(chol_a),
    .inv_step(inv_a), .div_sel(ds_a), .div_issue(di_a),
    .mult_sel(ms_a), .mult_issue(mi_a)
  );

  chol_inv_sched #(.N(NB), .SQRT_LAT(SB), .DIV_LAT(DB), .MAC_LAT(MB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .col(col_b), .chol_step(chol_b),
    .inv_step(inv_b), .div_sel(ds_b), .div_issue(di_b),
    .mult_sel(ms_b), .mult_issue(mi_b)
  );

  int  checks = 0, errors = 0, cyc = 0;
  bit  run_a = 0, run_b = 0;
  int  k_a = 0, k_b = 0;
  int  ndiv = 0, nmult = 0, nbusy = 0, ndone = 0;

  // Expected outputs k cycles into a run (k = 0 is the first SQRT cycle).
  function automatic exp_t ref_out(int n, int sl, int dl, int ml, bit run, int k);
    exp_t e;
    int p, c, o;
    e = '0;
    if (!run) return e;
    p = sl + dl + 2 * ml;
    e.busy = 1'b1;
    if (k >= n * p) begin
      e.done = 1'b1;
      e.col  = 3'(n - 1);
      e.chol = 5'(3 * n);
      e.inv  = 5'(2 * n);
      return e;
    end
    c = k / p;
    o = k % p;
    e.col = 3'(c);
    if (o < sl) begin
      e.chol = 5'(3 * c + 1);
      e.inv  = 5'(2 * c);
    end else if (o < sl + dl) begin
      e.chol = 5'(3 * c + 2);
      e.inv  = 5'(2 * c);
      e.ds   = 2'd1;
      e.di   = (o == sl);
    end else if (o < sl + dl + ml) begin
      e.chol = 5'(3 * c + 3);
      e.inv  = 5'(2 * c + 1);
      e.ds   = 2'd2;
      e.ms   = 2'd1;
      e.di   = (o == sl + dl);
      e.mi   = (o == sl + dl);
    end else begin
      e.chol = 5'(3 * c + 3);
      e.inv  = 5'(2 * c + 2);
      e.ms   = 2'd2;
      e.mi   = (o == sl + dl + ml);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic cmp(input string p, input exp_t o, input exp_t e);
    chk({p, "_col"},  32'(o.col),  32'(e.col));
    chk({p, "_chol"}, 32'(o.chol), 32'(e.chol));
    chk({p, "_inv"},  32'(o.inv),  32'(e.inv));
    chk({p, "_dsel"}, 32'(o.ds),   32'(e.ds));
    chk({p, "_msel"}, 32'(o.ms),   32'(e.ms));
    chk({p, "_diss"}, 32'(o.di),   32'(e.di));
    chk({p, "_miss"}, 32'(o.mi),   32'(e.mi));
    chk({p, "_busy"}, 32'(o.busy), 32'(e.busy));
    chk({p, "_done"}, 32'(o.done), 32'(e.done));
  endtask

  task automatic cmp_all();
    cmp("a", {col_a, chol_a, inv_a, ds_a, ms_a, di_a, mi_a, busy_a, done_a},
        ref_out(NA, SA, DA, MA, run_a, k_a));
    cmp("b", {col_b, chol_b, inv_b, ds_b, ms_b, di_b, mi_b, busy_b, done_b},
        ref_out(NB, SB, DB, MB, run_b, k_b));
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      run_a = 0;
      run_b = 0;
    end else begin
      if (run_a) begin
        if (abort_a || k_a == NA * PA) run_a = 0; else k_a++;
      end else if (start_a) begin
        run_a = 1; k_a = 0;
      end
      if (run_b) begin
        if (abort_b || k_b == NB * PB) run_b = 0; else k_b++;
      end else if (start_b) begin
        run_b = 1; k_b = 0;
      end
    end
    @(negedge clk);
    cmp_all();
    if (di_a === 1'b1) ndiv++;
    if (mi_a === 1'b1) nmult++;
    if (busy_a === 1'b1) nbusy++;
    if (done_a === 1'b1) ndone++;
  endtask

  task automatic wait_done_a(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      step();
      if (done_a === 1'b1) at = cyc;
    end
    chk("done_a_timeout", 32'(at >= 0), 32'd1);
  endtask

  initial begin
    int done_at, bdone, s_cyc, rise;
    rst_n = 1'b0; start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;

    // Reset state.
    @(negedge clk);
    cmp_all();
    repeat (2) step();
    rst_n = 1'b1;

    // Single default run, start sampled at edge 10, plus the N=2 instance.
    while (cyc < 10) step();
    start_a = 1; start_b = 1;
    ndiv = 0; nmult = 0; nbusy = 0;
    step();
    start_a = 0; start_b = 0;
    done_at = -1; bdone = -1;
    if (done_b === 1'b1) bdone = cyc;
    for (int i = 0; i < 200 && done_at < 0; i++) begin
      start_a = (cyc == 61);
      step();
      if (cyc == 33) begin
        chk("col0_next_col", 32'(col_a), 32'd1);
        chk("col0_next_chol", 32'(chol_a), 32'd4);
      end
      if (done_a === 1'b1) done_at = cyc;
      if (done_b === 1'b1 && bdone < 0) bdone = cyc;
    end
    start_a = 0;
    chk("done_cycle", 32'(done_at), 32'd143);
    chk("busy_cycles", 32'(nbusy), 32'd133);
    chk("div_pulses", 32'(ndiv), 32'd12);
    chk("mult_pulses", 32'(nmult), 32'd12);
    chk("final_chol", 32'(chol_a), 32'd18);
    chk("final_inv", 32'(inv_a), 32'd12);
    chk("small_done_cycle", 32'(bdone), 32'd19);
    start_a = 1;          // start in the DONE cycle is ignored
    step();
    start_a = 0;
    step();

    // Asynchronous reset in CMAC of column 2.
    start_a = 1;
    step();
    start_a = 0;
    for (int i = 0; i < 200 && k_a < 2 * PA + SA + DA + 2; i++) step();
    chk("rst_pre_col", 32'(col_a), 32'd2);
    chk("rst_pre_msel", 32'(ms_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    run_a = 0; run_b = 0;
    cmp_all();
    step();
    rst_n = 1'b1;
    ndone = 0;
    repeat (150) step();
    chk("no_done_after_rst", 32'(ndone), 32'd0);

    // Abort on the IMAC terminal cycle of column 3.
    start_a = 1;
    step();
    start_a = 0;
    ndone = 0;
    for (int i = 0; i < 200 && k_a < 3 * PA + PA - 1; i++) step();
    abort_a = 1;
    step();
    abort_a = 0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_no_done", 32'(ndone), 32'd0);
    repeat (3) step();
    start_a = 1;
    s_cyc = cyc;
    step();
    start_a = 0;
    wait_done_a(200, done_at);
    chk("rerun_done_cycle", 32'(done_at - s_cyc), 32'd133);

    // Start held high: back-to-back runs.
    step();
    start_a = 1;
    wait_done_a(200, done_at);
    rise = -1;
    for (int i = 0; i < 5 && rise < 0; i++) begin
      step();
      if (busy_a === 1'b1) rise = cyc;
    end
    chk("b2b_spacing", 32'(rise - done_at), 32'd2);
    start_a = 0;
    abort_a = 1;
    step();
    abort_a = 0;
    abort_b = 1;          // abort while idle has no effect
    step();
    abort_b = 0;

    // Randomised start/abort traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      start_a = ($urandom_range(0, 7) == 0);
      abort_a = ($urandom_range(0, 63) == 0);
      start_b = ($urandom_range(0, 3) == 0);
      abort_b = ($urandom_range(0, 15) == 0);
      step();
    end
    start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
